// File: rtl/modular_mac_column_pkg.sv
// ----------------------------------------------------------------------------
// he_mod_pkg
//   Shared modular-arithmetic helpers for the polynomial multiplier datapath.
//   DEFAULT_MODULUS : default ciphertext modulus q
//   barrett_k(q)    : K = clog2(q), so that q < 2**K (q is odd, never a power of 2)
//   barrett_mu(q)   : MU = floor(4**K / q), the Barrett reciprocal
//   mod_add(a,b,q)  : (a + b) mod q for a, b already in [0, q)
// ----------------------------------------------------------------------------
package he_mod_pkg;

    localparam int unsigned DEFAULT_MODULUS = 32'd12289;

    function automatic int unsigned barrett_k(input int unsigned q);
        return $clog2(q);
    endfunction

    // 64-bit intermediate keeps 4**K exact for any q below 2**31.
    function automatic longint unsigned barrett_mu(input int unsigned q);
        longint unsigned four_k;
        four_k = 64'd1 << (32'd2 * barrett_k(q));
        return four_k / 64'(q);
    endfunction

    // Operands are reduced, so a single conditional subtract suffices.
    function automatic logic [31:0] mod_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] q);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) begin
            s = s - {1'b0, q};
        end else begin
            s = s;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/modular_mac_column_barrett.sv
// ----------------------------------------------------------------------------
// barrett_reduce
//   Two-stage Barrett reduction of a product x < q**2 into [0, q).
//   Stage A: qhat = (x * MU) >> 2K, keep the low bits of x.
//   Stage B: r = x - qhat*q (known to lie in [0, 2q)), one conditional subtract.
// Ports
//   clk, nrst : clock, asynchronous active-low reset
//   en        : advance both stages (pipeline stall when low)
//   x         : 2*COEFF_WIDTH product input
//   r         : COEFF_WIDTH registered result in [0, q)
// ----------------------------------------------------------------------------
module barrett_reduce
    import he_mod_pkg::*;
#(
    parameter int          COEFF_WIDTH = 16,
    parameter int unsigned MODULUS     = DEFAULT_MODULUS
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       en,
    input  logic [2*COEFF_WIDTH-1:0]   x,
    output logic [COEFF_WIDTH-1:0]     r
);

    localparam int                   K     = int'(barrett_k(MODULUS));
    localparam int                   PW    = 2 * COEFF_WIDTH + K + 1;
    localparam logic [K:0]           MU    = (K + 1)'(barrett_mu(MODULUS));
    localparam logic [COEFF_WIDTH:0] Q_EXT = (COEFF_WIDTH + 1)'(MODULUS);

    logic [PW-1:0]          prod_s;
    logic [K:0]             qhat_s;
    logic [K:0]             qhat_r;
    logic [COEFF_WIDTH:0]   x_lo_r;
    logic [COEFF_WIDTH:0]   rem_s;

    assign prod_s = PW'(x) * PW'(MU);
    assign qhat_s = (K + 1)'(prod_s >> (2 * K));
    // The true remainder is below 2q < 2**(COEFF_WIDTH+1), so arithmetic
    // modulo 2**(COEFF_WIDTH+1) on the low bits of x is exact.
    assign rem_s  = x_lo_r - ((COEFF_WIDTH + 1)'(qhat_r) * Q_EXT);

    // Stage A: quotient estimate and retained low bits of x.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            qhat_r <= {(K + 1){1'b0}};
            x_lo_r <= {(COEFF_WIDTH + 1){1'b0}};
        end else if (en) begin
            qhat_r <= qhat_s;
            x_lo_r <= x[COEFF_WIDTH:0];
        end
    end

    // Stage B: final correction into [0, q).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r <= {COEFF_WIDTH{1'b0}};
        end else if (en) begin
            if (rem_s >= Q_EXT) begin
                r <= COEFF_WIDTH'(rem_s - Q_EXT);
            end else begin
                r <= rem_s[COEFF_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/modular_mac_column.sv
// ----------------------------------------------------------------------------
// modular_mac_column
//   Pipelined valid/ready dot-product column: per beat, sum over lanes of
//   +/- as[i]*bs[HEIGHT-1-i] mod q, accumulated across beats until in_last.
//   Stages: S1 product, S2-S3 Barrett, S4 negate, LEVELS add-tree levels,
//   accumulate/output. One global enable stalls every stage together.
// Ports
//   clk, nrst            : clock, asynchronous active-low reset
//   in_valid/in_ready    : input beat handshake; in_last closes a group
//   as, bs               : HEIGHT packed coefficients, each < MODULUS
//   neg_mask             : per-lane subtract (negacyclic wrap term)
//   out_valid/out_ready  : output handshake
//   c_value              : accumulated coefficient in [0, q)
// ----------------------------------------------------------------------------
module modular_mac_column
    import he_mod_pkg::*;
#(
    parameter int          HEIGHT      = 4,
    parameter int          COEFF_WIDTH = 16,
    parameter int unsigned MODULUS     = DEFAULT_MODULUS
) (
    input  logic                                  clk,
    input  logic                                  nrst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_last,
    input  logic [HEIGHT-1:0][COEFF_WIDTH-1:0]    as,
    input  logic [HEIGHT-1:0][COEFF_WIDTH-1:0]    bs,
    input  logic [HEIGHT-1:0]                     neg_mask,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [COEFF_WIDTH-1:0]                c_value
);

    localparam int                   LEVELS = $clog2(HEIGHT);
    localparam int                   NV     = 4 + LEVELS;
    localparam logic [COEFF_WIDTH-1:0] Q_C  = COEFF_WIDTH'(MODULUS);

    // Node count of tree level l (level 0 = negate stage outputs).
    function automatic int lvl_cnt(input int l);
        return (HEIGHT + (32'sd1 << l) - 32'sd1) >> l;
    endfunction

    // Offset of tree level l inside the flat node array.
    function automatic int lvl_off(input int l);
        int s;
        s = 0;
        for (int m = 0; m < l; m++) begin
            s = s + lvl_cnt(m);
        end
        return s;
    endfunction

    localparam int NODES = lvl_off(LEVELS) + 1;

    logic                         en_s;
    logic [2*COEFF_WIDTH-1:0]     prod_r [HEIGHT];
    logic [COEFF_WIDTH-1:0]       red_s  [HEIGHT];
    logic [HEIGHT-1:0]            mask_r [3];
    logic [NV-1:0]                vld_r;
    logic [NV-1:0]                last_r;
    logic [COEFF_WIDTH-1:0]       node_r [NODES];
    logic [COEFF_WIDTH-1:0]       tree_sum_s;
    logic [COEFF_WIDTH-1:0]       acc_r;
    logic [COEFF_WIDTH-1:0]       acc_new_s;
    logic                         first_r;

    // Only a held, unaccepted result blocks the pipe.
    assign en_s       = !(out_valid && !out_ready);
    assign in_ready   = en_s;
    assign tree_sum_s = node_r[NODES-1];

    // S1: raw lane products.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < HEIGHT; i++) begin
                prod_r[i] <= {(2 * COEFF_WIDTH){1'b0}};
            end
        end else if (en_s) begin
            for (int i = 0; i < HEIGHT; i++) begin
                prod_r[i] <= (2 * COEFF_WIDTH)'(as[i]) * (2 * COEFF_WIDTH)'(bs[HEIGHT-1-i]);
            end
        end
    end

    // Valid/last shift chain plus neg_mask carried to the negate stage.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_r     <= {NV{1'b0}};
            last_r    <= {NV{1'b0}};
            mask_r[0] <= {HEIGHT{1'b0}};
            mask_r[1] <= {HEIGHT{1'b0}};
            mask_r[2] <= {HEIGHT{1'b0}};
        end else if (en_s) begin
            vld_r     <= {vld_r[NV-2:0], in_valid};
            last_r    <= {last_r[NV-2:0], in_last};
            mask_r[0] <= neg_mask;
            mask_r[1] <= mask_r[0];
            mask_r[2] <= mask_r[1];
        end
    end

    for (genvar i = 0; i < HEIGHT; i++) begin : g_lane
        barrett_reduce #(
            .COEFF_WIDTH (COEFF_WIDTH),
            .MODULUS     (MODULUS)
        ) u_red (
            .clk  (clk),
            .nrst (nrst),
            .en   (en_s),
            .x    (prod_r[i]),
            .r    (red_s[i])
        );

        // S4: modular negate; zero stays zero so results remain in [0, q).
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                node_r[i] <= {COEFF_WIDTH{1'b0}};
            end else if (en_s) begin
                if (mask_r[2][i] && (red_s[i] != {COEFF_WIDTH{1'b0}})) begin
                    node_r[i] <= Q_C - red_s[i];
                end else begin
                    node_r[i] <= red_s[i];
                end
            end
        end
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int NIN  = lvl_cnt(l - 1);
        localparam int NOUT = lvl_cnt(l);
        localparam int IOFF = lvl_off(l - 1);
        localparam int OOFF = lvl_off(l);
        for (genvar j = 0; j < NOUT; j++) begin : g_node
            if (2 * j + 1 < NIN) begin : g_add
                // Tree node: modular sum of a pair from the level below.
                always_ff @(posedge clk or negedge nrst) begin
                    if (!nrst) begin
                        node_r[OOFF+j] <= {COEFF_WIDTH{1'b0}};
                    end else if (en_s) begin
                        node_r[OOFF+j] <= COEFF_WIDTH'(mod_add(32'(node_r[IOFF+2*j]),
                                                               32'(node_r[IOFF+2*j+1]),
                                                               32'(MODULUS)));
                    end
                end
            end else begin : g_pass
                // Tree node: unpaired odd operand, registered to stay aligned.
                always_ff @(posedge clk or negedge nrst) begin
                    if (!nrst) begin
                        node_r[OOFF+j] <= {COEFF_WIDTH{1'b0}};
                    end else if (en_s) begin
                        node_r[OOFF+j] <= node_r[IOFF+2*j];
                    end
                end
            end
        end
    end

    // Next accumulator value: a group's first beat restarts the sum.
    always_comb begin
        acc_new_s = tree_sum_s;
        if (first_r) begin
            acc_new_s = tree_sum_s;
        end else begin
            acc_new_s = COEFF_WIDTH'(mod_add(32'(acc_r), 32'(tree_sum_s), 32'(MODULUS)));
        end
    end

    // Accumulate/output stage; an enabled cycle with no new result means the
    // previous output (if any) was just accepted.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc_r     <= {COEFF_WIDTH{1'b0}};
            first_r   <= 1'b1;
            out_valid <= 1'b0;
            c_value   <= {COEFF_WIDTH{1'b0}};
        end else if (en_s) begin
            out_valid <= vld_r[NV-1] && last_r[NV-1];
            if (vld_r[NV-1]) begin
                acc_r <= acc_new_s;
                if (last_r[NV-1]) begin
                    c_value <= acc_new_s;
                    first_r <= 1'b1;
                end else begin
                    first_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_modular_mac_column.sv
module tb_modular_mac_column;

    localparam int H  = 4;
    localparam int CW = 16;
    localparam int Q  = 12289;

    typedef logic [H-1:0][CW-1:0] lanes_t;

    typedef struct {
        string          name;
        lanes_t         a;
        lanes_t         b;
        logic [H-1:0]   m;
        int             exp;
    } vec_t;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           out_ready = 1'b1;
    logic           in_ready;
    logic           out_valid;
    logic [CW-1:0]  c_value;
    lanes_t         as_d = '0;
    lanes_t         bs_d = '0;
    logic [H-1:0]   mask_d = '0;

    int  n_checks = 0;
    int  n_fail = 0;
    int  n_out = 0;
    int  cyc = 0;
    int  stall_cycles = 0;
    bit  stall_on = 1'b0;
    int  stall_lo = 0;
    int  stall_hi = 0;
    int  exp_q[$];
    int  mdl_acc = 0;
    bit  mdl_first = 1'b1;
    bit  hold_v = 1'b0;
    logic [CW-1:0] hold_c = '0;
    vec_t tbl[9];

    always #5 clk = ~clk;

    modular_mac_column #(.HEIGHT(H), .COEFF_WIDTH(CW), .MODULUS(Q)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .as        (as_d),
        .bs        (bs_d),
        .neg_mask  (mask_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_value   (c_value)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Independent reference: signed dot product reduced with % q.
    function automatic int beat_sum(input lanes_t a, input lanes_t b, input logic [H-1:0] m);
        longint s;
        longint p;
        s = 0;
        for (int i = 0; i < H; i++) begin
            p = (longint'(a[i]) * longint'(b[H-1-i])) % Q;
            s = m[i] ? s - p : s + p;
        end
        s = s % Q;
        if (s < 0) s = s + Q;
        return int'(s);
    endfunction

    function automatic vec_t mk(input string nm, input lanes_t a, input lanes_t b,
                                input logic [H-1:0] m, input int e);
        vec_t v;
        v.name = nm; v.a = a; v.b = b; v.m = m; v.exp = e;
        return v;
    endfunction

    function automatic lanes_t rnd_lanes();
        lanes_t r;
        for (int i = 0; i < H; i++) r[i] = CW'($urandom_range(0, Q - 1));
        return r;
    endfunction

    // Present one beat and hold it until the DUT accepts it (bounded).
    task automatic send(input lanes_t a, input lanes_t b, input logic [H-1:0] m, input logic last);
        bit ok;
        ok = 1'b0;
        as_d = a; bs_d = b; mask_d = m; in_last = last; in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        check("send_accepted", ok, 1);
    endtask

    task automatic send_model(input lanes_t a, input lanes_t b, input logic [H-1:0] m, input logic last);
        int s;
        s = beat_sum(a, b, m);
        if (mdl_first) mdl_acc = s;
        else mdl_acc = (mdl_acc + s) % Q;
        mdl_first = last;
        send(a, b, m, last);
        if (last) exp_q.push_back(mdl_acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (12) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Cycle counter and downstream ready pattern, updated just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            out_ready = !(stall_on && cyc >= stall_lo && cyc <= stall_hi);
        end
    end

    // Scoreboard monitor: pops on each output handshake, checks hold behaviour.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_value", c_value, hold_c);
                end
                if (out_valid && !out_ready) begin
                    stall_cycles++;
                    check("in_ready_stalled", in_ready, 0);
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %0d, required no output", c_value);
                    end else begin
                        e = exp_q.pop_front();
                        check("c_value", c_value, e);
                    end
                end
                hold_v = out_valid && !out_ready;
                hold_c = c_value;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lanes_t a1, b1, allq, z, a5, b5, a6, b6, a7, b7;
        int lat, n_before, glen, start;
        a1 = {16'd4, 16'd3, 16'd2, 16'd1};
        b1 = {16'd8, 16'd7, 16'd6, 16'd5};
        allq = {4{16'd12288}};
        z  = '0;
        a5 = {16'd0, 16'd0, 16'd0, 16'd12288};
        b5 = {16'd12288, 16'd0, 16'd0, 16'd0};
        a6 = {16'd400, 16'd300, 16'd200, 16'd100};
        b6 = {16'd1, 16'd1, 16'd1, 16'd1};
        a7 = {16'd0, 16'd0, 16'd6000, 16'd6000};
        b7 = {16'd2, 16'd2, 16'd0, 16'd0};
        tbl[0] = mk("basic",       a1,   b1,   4'b0000, 60);
        tbl[1] = mk("neg_lane3",   a1,   b1,   4'b1000, 20);
        tbl[2] = mk("all_max",     allq, allq, 4'b0000, 4);
        tbl[3] = mk("all_max_neg", allq, allq, 4'b1111, 12285);
        tbl[4] = mk("zero_neg",    z,    z,    4'b1111, 0);
        tbl[5] = mk("single_neg",  a5,   b5,   4'b0001, 12288);
        tbl[6] = mk("scale",       a6,   b6,   4'b0000, 1000);
        tbl[7] = mk("wrap",        a7,   b7,   4'b0000, 11711);
        tbl[8] = mk("wrap_neg",    a7,   b7,   4'b0011, 578);

        // Reset state
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_c_value", c_value, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Latency of a single-beat group: edges counted from the accepting one
        exp_q.push_back(60);
        send(a1, b1, 4'b0000, 1'b1);
        lat = 1;
        while (lat < 50) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("latency", lat, 7);
        drain();

        // Table vectors, back to back
        n_before = n_out;
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].m, 1'b1);
            exp_q.push_back(tbl[i].exp);
        end
        drain();
        check("table_count", n_out - n_before, 9);

        // Two-beat group: one output only
        n_before = n_out;
        send(a1, b1, 4'b0000, 1'b0);
        send(a1, b1, 4'b0000, 1'b1);
        exp_q.push_back(120);
        drain();
        check("two_beat_count", n_out - n_before, 1);

        // Random groups of 1..3 beats
        for (int g = 0; g < 12; g++) begin
            glen = $urandom_range(1, 3);
            for (int k = 0; k < glen; k++) begin
                send_model(rnd_lanes(), rnd_lanes(), H'($urandom_range(0, 15)), (k == glen - 1));
            end
        end
        drain();

        // Single-beat stream with out_ready low for output-stream cycles 3-7
        n_before = n_out;
        stall_cycles = 0;
        start = cyc;
        stall_lo = start + 7 + 3;
        stall_hi = start + 7 + 7;
        stall_on = 1'b1;
        for (int k = 0; k < 10; k++) begin
            send_model(rnd_lanes(), rnd_lanes(), H'($urandom_range(0, 15)), 1'b1);
        end
        drain();
        stall_on = 1'b0;
        check("stream_count", n_out - n_before, 10);
        check("stall_exercised", (stall_cycles > 0), 1);

        // Reset in the middle of a two-beat group
        send(a1, b1, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        mdl_first = 1'b1;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_c_value", c_value, 0);
        repeat (2) @(negedge clk);
        check("midreset_hold_c_value", c_value, 0);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        n_before = n_out;
        send(a1, b1, 4'b0000, 1'b1);
        exp_q.push_back(60);
        drain();
        check("post_reset_count", n_out - n_before, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
